// File: rtl/simon_pkg.sv
// Types shared by the blinker, pattern memory and input checker.
package simon_pkg;

    localparam int NUM_LEDS = 4;

    typedef logic [1:0] led_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_PRESS,
        COMPARE,
        WAIT_RELEASE,
        PASS,
        FAIL
    } chk_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Accepts a key once exactly one button has been low for DEB_CYCLES consecutive
// cycles; reports release once all buttons have been high for DEB_CYCLES cycles.
module key_debouncer
    import simon_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] btn_n,
    output logic                pressed,
    output led_idx_t            idx,
    output logic                released
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [NUM_LEDS-1:0] low;
    logic                one_low;
    led_idx_t            low_idx;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    led_idx_t      key_q, key_d;
    logic          pressed_q, pressed_d;

    always_comb begin
        low     = ~btn_n;
        one_low = $onehot(low);
        low_idx = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (low[i]) low_idx = led_idx_t'(i);
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        key_d     = key_q;
        pressed_d = 1'b0;
        rel_d     = rel_q;

        // A different key, or several keys at once, restarts the count.
        if (one_low) begin
            if (cnt_q == '0 || low_idx != key_q) begin
                key_d     = low_idx;
                cnt_d     = CW'(1);
                pressed_d = (FULL == CW'(1));
            end else if (cnt_q != FULL) begin
                cnt_d     = cnt_q + CW'(1);
                pressed_d = (cnt_q == LAST);
            end
        end else begin
            cnt_d = '0;
        end

        if (low == '0) begin
            if (rel_q != FULL) rel_d = rel_q + CW'(1);
        end else begin
            rel_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            rel_q     <= '0;
            key_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
        end
    end

    assign pressed  = pressed_q;
    assign idx      = key_q;
    assign released = (rel_q == FULL);

endmodule

// File: rtl/input_checker.sv
// Player-response checker: debounces keys, compares each accepted key with the
// expected LED index from pattern memory and reports pass/fail to the game FSM.
//
// state        | meaning
// IDLE         | waiting for start
// LOAD         | address presented, memory data settling
// WAIT_PRESS   | waiting for an accepted key, timeout running
// COMPARE      | accepted key vs expected index
// WAIT_RELEASE | correct key still held, waiting for all keys up
// PASS / FAIL  | one-cycle exit back to IDLE
module input_checker
    import simon_pkg::*;
#(
    parameter int unsigned ms         = 1_000_000,
    parameter int unsigned DEB_MS     = 20,
    parameter int unsigned TIMEOUT_MS = 3000,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          level,
    input  logic [NUM_LEDS-1:0] btn_n,
    input  led_idx_t            mem_data,
    output logic [3:0]          mem_addr,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic                done,
    output logic [9:0]          led_echo
);

    localparam int unsigned   DEB_CYCLES = DEB_MS * ms;
    localparam int unsigned   TMO_CYCLES = TIMEOUT_MS * ms;
    localparam logic [31:0]   TMO_LAST   = 32'(TMO_CYCLES - 1);
    localparam logic [4:0]    DEPTH_C    = 5'(MEM_DEPTH);

    chk_state_t  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  addr_q, addr_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] tmo_q, tmo_d;
    led_idx_t    acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        done_q, done_d;

    logic        deb_pressed, deb_released;
    led_idx_t    deb_idx;

    key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .pressed  (deb_pressed),
        .idx      (deb_idx),
        .released (deb_released)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        len_d   = len_q;
        tmo_d   = tmo_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        done_d  = 1'b0;

        // Flags are set on entry to PASS/FAIL so they rise right after the deciding cycle.
        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    idx_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    len_d   = ({1'b0, level} > DEPTH_C) ? DEPTH_C : {1'b0, level};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tmo_d = '0;
                if (len_q == '0) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (deb_pressed) begin
                    acc_d   = deb_idx;
                    state_d = COMPARE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            COMPARE: begin
                if (acc_q != mem_data) begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if ({1'b0, idx_q} == len_q - 5'd1) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (deb_released) begin
                    idx_d   = idx_q + 4'd1;
                    addr_d  = idx_q + 4'd1;
                    state_d = LOAD;
                end
            end
            PASS, FAIL: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign done     = done_q;
    assign led_echo = (state_q == COMPARE || state_q == WAIT_RELEASE) ? (10'd1 << acc_q) : 10'd0;

endmodule

// File: tb/tb_input_checker.sv
// Directed bench for input_checker: ms=10, DEB_MS=2, TIMEOUT_MS=50 (20-cycle
// debounce, 500-cycle timeout) with a one-cycle behavioural pattern memory.
module tb_input_checker;
    import simon_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, start2;
    logic [3:0] level, level2, btn_n, btn_n2;
    led_idx_t   mem_data, mem_data2;
    logic [3:0] mem_addr, mem_addr2;
    logic       busy, pass, fail, done;
    logic       busy2, pass2, fail2, done2;
    logic [9:0] led_echo, led_echo2;

    led_idx_t   mem [16];

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    logic       seen_done, seen_pass, seen_fail, seen_busy;
    int         seen_k, seen_step;
    logic [3:0] seen_addr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= mem[mem_addr];
        mem_data2 <= mem[mem_addr2];
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    input_checker #(.ms(10), .DEB_MS(2), .TIMEOUT_MS(50), .MEM_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .level(level), .btn_n(btn_n),
        .mem_data(mem_data), .mem_addr(mem_addr), .busy(busy), .pass(pass),
        .fail(fail), .done(done), .led_echo(led_echo)
    );

    input_checker #(.ms(10), .DEB_MS(2), .TIMEOUT_MS(50), .MEM_DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start2), .level(level2), .btn_n(btn_n2),
        .mem_data(mem_data2), .mem_addr(mem_addr2), .busy(busy2), .pass(pass2),
        .fail(fail2), .done(done2), .led_echo(led_echo2)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input bit d2, input logic [3:0] lv);
        @(negedge clk);
        if (d2) begin level2 = lv; start2 = 1'b1; end
        else    begin level  = lv; start  = 1'b1; end
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic clear_seen();
        seen_done = 1'b0; seen_pass = 1'b0; seen_fail = 1'b0; seen_busy = 1'b1;
        seen_k = 0; seen_step = -1; seen_addr = '0;
    endtask

    // Drives a button pattern for a number of cycles, recording the first done pulse.
    task automatic hold_btn(input bit d2, input logic [3:0] val, input int cycles, input int step);
        if (d2) btn_n2 = val; else btn_n = val;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (!seen_done && (d2 ? done2 : done) === 1'b1) begin
                seen_done = 1'b1;
                seen_k    = k;
                seen_step = step;
                seen_pass = d2 ? pass2 : pass;
                seen_fail = d2 ? fail2 : fail;
                seen_busy = d2 ? busy2 : busy;
                seen_addr = d2 ? mem_addr2 : mem_addr;
            end
        end
    endtask

    task automatic press(input bit d2, input int key, input int cycles, input int step);
        logic [3:0] v;
        v = 4'b0001 << key;
        hold_btn(d2, ~v, cycles, step);
    endtask

    task automatic load_pattern();
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if ({pass, fail, done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {pass, fail, done}); else n_pass++;
        n_total++; if (mem_addr !== 4'd0) $display("FAIL reset_addr: got %0d expected 0", mem_addr); else n_pass++;
        n_total++; if (led_echo !== 10'd0) $display("FAIL reset_led: got %b expected 0", led_echo); else n_pass++;
        reset = 1'b1;
        tick(25);
    endtask

    task automatic test_correct_round();
        load_pattern();
        clear_seen();
        do_start(1'b0, 4'd4);
        n_total++; if (busy !== 1'b1) $display("FAIL round_busy: got %b expected 1", busy); else n_pass++;
        press(1'b0, 2, 25, 0);
        n_total++; if (led_echo !== 10'b0000000100) $display("FAIL round_led_echo: got %b expected 0000000100", led_echo); else n_pass++;
        press(1'b0, 2, 15, 0);
        hold_btn(1'b0, 4'hF, 30, 0);
        for (int s = 1; s < 4; s++) begin
            press(1'b0, int'(mem[s]), 40, s);
            hold_btn(1'b0, 4'hF, 30, s);
        end
        n_total++; if (!(seen_done === 1'b1 && seen_step == 3)) $display("FAIL round_done_step: got done=%b step=%0d expected done=1 step=3", seen_done, seen_step); else n_pass++;
        n_total++; if ({seen_pass, seen_fail, seen_busy} !== 3'b100) $display("FAIL round_flags_at_done: got pass/fail/busy=%b expected 100", {seen_pass, seen_fail, seen_busy}); else n_pass++;
        n_total++; if (!(seen_k >= 21 && seen_k <= 23)) $display("FAIL round_done_while_held: got cycle %0d expected 21..23", seen_k); else n_pass++;
    endtask

    task automatic test_wrong_key();
        load_pattern();
        clear_seen();
        do_start(1'b0, 4'd4);
        press(1'b0, 2, 40, 0);
        hold_btn(1'b0, 4'hF, 30, 0);
        press(1'b0, 1, 40, 1);
        hold_btn(1'b0, 4'hF, 30, 1);
        n_total++; if (!(seen_done === 1'b1 && seen_step == 1)) $display("FAIL wrong_done: got done=%b step=%0d expected done=1 step=1", seen_done, seen_step); else n_pass++;
        n_total++; if ({seen_pass, seen_fail} !== 2'b01) $display("FAIL wrong_flags: got pass/fail=%b expected 01", {seen_pass, seen_fail}); else n_pass++;
        n_total++; if (seen_addr !== 4'd1) $display("FAIL wrong_addr: got %0d expected 1", seen_addr); else n_pass++;
        n_total++; if (!(seen_k >= 21 && seen_k <= 23)) $display("FAIL wrong_timing: got cycle %0d expected 21..23", seen_k); else n_pass++;
    endtask

    task automatic test_bounce();
        int dc0, acc_k, bounce_led;
        mem[0] = 2'd2;
        clear_seen();
        do_start(1'b0, 4'd1);
        n_total++; if (fail !== 1'b0) $display("FAIL bounce_fail_cleared: got %b expected 0", fail); else n_pass++;
        dc0 = done_cnt;
        bounce_led = 0;
        for (int c = 0; c < 60; c++) begin
            btn_n = (((c / 5) % 2) == 0) ? 4'b1011 : 4'b1111;
            @(negedge clk);
            if (led_echo !== 10'd0) bounce_led++;
        end
        n_total++; if (bounce_led != 0 || done_cnt != dc0) $display("FAIL bounce_no_accept: got led=%0d done=%0d expected 0 0", bounce_led, done_cnt - dc0); else n_pass++;
        btn_n = 4'b1011;
        acc_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (acc_k == 0 && led_echo === 10'b0000000100) acc_k = k;
        end
        n_total++; if (!(acc_k >= 19 && acc_k <= 23)) $display("FAIL bounce_accept_time: got cycle %0d expected 19..23", acc_k); else n_pass++;
        n_total++; if (done_cnt - dc0 != 1 || pass !== 1'b1) $display("FAIL bounce_single_accept: got done=%0d pass=%b expected 1 1", done_cnt - dc0, pass); else n_pass++;
        btn_n = 4'hF;
        tick(25);
    endtask

    task automatic test_timeout();
        int k_done;
        do_start(1'b0, 4'd4);
        k_done = 0;
        for (int k = 1; k <= 700 && k_done == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) k_done = k;
        end
        n_total++; if (!(k_done >= 499 && k_done <= 503)) $display("FAIL timeout_cycles: got %0d expected 499..503", k_done); else n_pass++;
        n_total++; if ({pass, fail, busy} !== 3'b010) $display("FAIL timeout_flags: got pass/fail/busy=%b expected 010", {pass, fail, busy}); else n_pass++;
    endtask

    task automatic test_zero_len();
        int k_pass;
        do_start(1'b0, 4'd0);
        k_pass = 0;
        for (int k = 1; k <= 5 && k_pass == 0; k++) begin
            if (pass === 1'b1 && done === 1'b1) k_pass = k;
            else @(negedge clk);
        end
        n_total++; if (!(k_pass >= 1 && k_pass <= 3)) $display("FAIL zero_len_pass: got %0d expected 1..3", k_pass); else n_pass++;
    endtask

    task automatic test_depth_sat();
        for (int i = 0; i < 8; i++) mem[i] = led_idx_t'(i % 4);
        clear_seen();
        do_start(1'b1, 4'd15);
        for (int s = 0; s < 8; s++) begin
            press(1'b1, int'(mem[s]), 40, s);
            hold_btn(1'b1, 4'hF, 30, s);
        end
        n_total++; if (!(seen_done === 1'b1 && seen_step == 7)) $display("FAIL depth_done_step: got done=%b step=%0d expected done=1 step=7", seen_done, seen_step); else n_pass++;
        n_total++; if ({seen_pass, seen_fail} !== 2'b10) $display("FAIL depth_flags: got pass/fail=%b expected 10", {seen_pass, seen_fail}); else n_pass++;
        n_total++; if (seen_addr !== 4'd7) $display("FAIL depth_addr: got %0d expected 7", seen_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_round();
        int dc0;
        load_pattern();
        clear_seen();
        do_start(1'b0, 4'd4);
        press(1'b0, 2, 40, 0);
        hold_btn(1'b0, 4'hF, 30, 0);
        press(1'b0, 0, 30, 1);
        n_total++; if (led_echo !== 10'b0000000001) $display("FAIL mid_wait_release_led: got %b expected 0000000001", led_echo); else n_pass++;
        dc0 = done_cnt;
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        n_total++; if ({busy, pass, fail, done} !== 4'b0000) $display("FAIL mid_reset_flags: got %b expected 0000", {busy, pass, fail, done}); else n_pass++;
        n_total++; if (mem_addr !== 4'd0 || led_echo !== 10'd0) $display("FAIL mid_reset_addr_led: got addr=%0d led=%b expected 0 0", mem_addr, led_echo); else n_pass++;
        start = 1'b0;
        btn_n = 4'hF;
        tick(3);
        reset = 1'b1;
        tick(25);
        n_total++; if (busy !== 1'b0 || done_cnt != dc0) $display("FAIL mid_no_done: got busy=%b done=%0d expected 0 0", busy, done_cnt - dc0); else n_pass++;
        clear_seen();
        do_start(1'b0, 4'd2);
        press(1'b0, 2, 40, 0);
        hold_btn(1'b0, 4'hF, 30, 0);
        press(1'b0, 0, 40, 1);
        hold_btn(1'b0, 4'hF, 30, 1);
        n_total++; if (!(seen_done === 1'b1 && seen_pass === 1'b1 && seen_fail === 1'b0)) $display("FAIL mid_clean_round: got done=%b pass=%b fail=%b expected 1 1 0", seen_done, seen_pass, seen_fail); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        level = '0; level2 = '0; btn_n = 4'hF; btn_n2 = 4'hF;
        test_reset();
        test_correct_round();
        test_wrong_key();
        test_bounce();
        test_timeout();
        test_zero_len();
        test_depth_sat();
        test_reset_mid_round();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000 expected earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
